// File: rtl/lamp_sequence_monitor_if.sv
// Lamp monitor bus: sequencer code and fault clear in, registered lamp drive and fault status out.
interface lamp_sequence_monitor_if;
    logic [2:0] light_in;
    logic       clear_fault;
    logic [2:0] lamp_out;
    logic       fault;
    logic [1:0] fault_code;

    modport master (
        output light_in,
        output clear_fault,
        input  lamp_out,
        input  fault,
        input  fault_code
    );

    modport slave (
        input  light_in,
        input  clear_fault,
        output lamp_out,
        output fault,
        output fault_code
    );
endinterface

// File: rtl/lamp_sequence_monitor.sv
// Deglitches the sequencer's one-hot light code, checks RED->GREEN->YELLOW order and drives the lamps.
// Optional sequencer watchdog is built in when LAMP_SEQ_MON_WDOG_EN is defined.
//
// state | meaning
// INIT  | no code accepted yet, lamps show RED
// RUN   | following the legal RED->GREEN->YELLOW->RED sequence
// FAULT | fault latched, flashing yellow until clear_fault
module lamp_sequence_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int FLASH_HALF    = 8,
    parameter int WDOG_CYCLES   = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lamp_sequence_monitor_if.slave bus
);

    localparam int CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam int FLASH_W = $clog2(FLASH_HALF + 1);

    localparam logic [CNT_W-1:0]   CNT_SAT    = CNT_W'(STABLE_CYCLES);
    localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(FLASH_HALF - 1);

    localparam logic [2:0] RED    = 3'b001;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] YELLOW = 3'b100;
    localparam logic [2:0] DARK   = 3'b000;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_ILLEGAL = 2'b01;
    localparam logic [1:0] CODE_SEQ     = 2'b10;
    localparam logic [1:0] CODE_WDOG    = 2'b11;

    logic [2:0]         s;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               acc;
    logic [1:0]         state;
    logic [2:0]         lamp_r;
    logic               fault_r;
    logic [1:0]         code_r;
    logic [FLASH_W-1:0] flash_cnt;
    logic [2:0]         succ;
    logic               clear_now;
    logic               take;
    logic               fault_req;
    logic [1:0]         fault_req_code;
    logic               wd_expired;

    assign clear_now = (state == ST_FAULT) && bus.clear_fault;

    // Run-length filter: a code is accepted once, on the sample that completes a stable run.
    always_comb begin
        cnt_next = cnt;
        if (bus.light_in != s) begin
            cnt_next = CNT_W'(1);
        end else if (cnt != CNT_SAT) begin
            cnt_next = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s   <= 3'b000;
            cnt <= '0;
            acc <= 1'b0;
        end else begin
            s <= bus.light_in;
            if (clear_now) begin
                cnt <= '0;
                acc <= 1'b0;
            end else begin
                cnt <= cnt_next;
                acc <= (cnt_next == CNT_SAT) && (cnt != CNT_SAT);
            end
        end
    end

    always_comb begin
        case (lamp_r)
            RED:     succ = GREEN;
            GREEN:   succ = YELLOW;
            YELLOW:  succ = RED;
            default: succ = RED;
        endcase
    end

`ifdef LAMP_SEQ_MON_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(WDOG_CYCLES - 1);

    logic [WD_W-1:0] wd;

    assign wd_expired = (state == ST_RUN) && (wd == '0);

    // Reloaded only by accepts that move the lamps; a repeated code does not count as progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd <= '0;
        end else if (fault_req || (state != ST_RUN && !take)) begin
            wd <= '0;
        end else if (take) begin
            wd <= WD_LOAD;
        end else if (wd != '0) begin
            wd <= wd - 1'b1;
        end
    end
`else
    assign wd_expired = 1'b0;
`endif

    // An accept is judged before the watchdog, so a bad code reports its own fault code.
    always_comb begin
        take           = 1'b0;
        fault_req      = 1'b0;
        fault_req_code = CODE_NONE;
        if (acc && state != ST_FAULT) begin
            if (!$onehot(s)) begin
                fault_req      = 1'b1;
                fault_req_code = CODE_ILLEGAL;
            end else if (state == ST_INIT || s == succ) begin
                take = 1'b1;
            end else if (s != lamp_r) begin
                fault_req      = 1'b1;
                fault_req_code = CODE_SEQ;
            end
        end
        if (wd_expired && !take && !fault_req) begin
            fault_req      = 1'b1;
            fault_req_code = CODE_WDOG;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            lamp_r    <= RED;
            fault_r   <= 1'b0;
            code_r    <= CODE_NONE;
            flash_cnt <= '0;
        end else begin
            case (state)
                ST_INIT, ST_RUN: begin
                    if (fault_req) begin
                        state     <= ST_FAULT;
                        lamp_r    <= YELLOW;
                        fault_r   <= 1'b1;
                        code_r    <= fault_req_code;
                        flash_cnt <= FLASH_LOAD;
                    end else if (take) begin
                        state  <= ST_RUN;
                        lamp_r <= s;
                    end
                end
                ST_FAULT: begin
                    if (bus.clear_fault) begin
                        state     <= ST_INIT;
                        lamp_r    <= RED;
                        fault_r   <= 1'b0;
                        code_r    <= CODE_NONE;
                        flash_cnt <= '0;
                    end else if (flash_cnt == '0) begin
                        lamp_r    <= (lamp_r == YELLOW) ? DARK : YELLOW;
                        flash_cnt <= FLASH_LOAD;
                    end else begin
                        flash_cnt <= flash_cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= ST_INIT;
                    lamp_r <= RED;
                end
            endcase
        end
    end

    assign bus.lamp_out   = lamp_r;
    assign bus.fault      = fault_r;
    assign bus.fault_code = code_r;

endmodule

// File: tb/tb_lamp_sequence_monitor.sv
// Bench for lamp_sequence_monitor: history-based reference model compared every cycle, plus literal spot checks.
module tb_lamp_sequence_monitor;

    localparam int S = 4;
    localparam int F = 8;
    localparam int W = 64;
`ifdef LAMP_SEQ_MON_WDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    localparam int M_INIT  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FAULT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    lamp_sequence_monitor_if bus ();

    lamp_sequence_monitor #(
        .STABLE_CYCLES(S),
        .FLASH_HALF   (F),
        .WDOG_CYCLES  (W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: decisions are derived from the sample history, not from a filter counter.
    logic [2:0] hist [0:4095];
    int         n_edge  = 0;
    int         restart = 0;
    int         mode    = M_INIT;
    int         fentry  = 0;
    int         reload  = 0;
    int         m_len   = 0;
    bit         pend    = 1'b0;
    bit         took    = 1'b0;
    logic [2:0] pval    = 3'b000;
    logic [2:0] m_lamp  = 3'b001;
    logic       m_fault = 1'b0;
    logic [1:0] m_code  = 2'b00;

    function automatic logic [2:0] next_colour(input logic [2:0] c);
        case (c)
            3'b001:  return 3'b010;
            3'b010:  return 3'b100;
            3'b100:  return 3'b001;
            default: return 3'b111;
        endcase
    endfunction

    task automatic enter_fault(input logic [1:0] c);
        mode    = M_FAULT;
        m_fault = 1'b1;
        m_code  = c;
        fentry  = n_edge;
        m_lamp  = 3'b100;
    endtask

    initial forever begin
        @(posedge clk);
        n_edge++;
        if (!rst_n) begin
            mode    = M_INIT;
            m_lamp  = 3'b001;
            m_fault = 1'b0;
            m_code  = 2'b00;
            pend    = 1'b0;
            restart = n_edge;
        end else begin
            hist[n_edge] = bus.light_in;
            if (mode == M_FAULT) begin
                if (bus.clear_fault) begin
                    mode    = M_INIT;
                    m_lamp  = 3'b001;
                    m_fault = 1'b0;
                    m_code  = 2'b00;
                    restart = n_edge;
                end else begin
                    m_lamp = (((n_edge - fentry) / F) % 2 == 0) ? 3'b100 : 3'b000;
                end
            end else begin
                took = 1'b0;
                if (pend) begin
                    if ($countones(pval) != 1) begin
                        enter_fault(2'b01);
                    end else if (mode == M_INIT || pval == next_colour(m_lamp)) begin
                        mode   = M_RUN;
                        m_lamp = pval;
                        reload = n_edge;
                        took   = 1'b1;
                    end else if (pval != m_lamp) begin
                        enter_fault(2'b10);
                    end
                end
                if (WD_ON && mode == M_RUN && !took && (n_edge - reload) >= W) begin
                    enter_fault(2'b11);
                end
            end
            m_len = 0;
            for (int m = n_edge; m > restart && m_len <= S && hist[m] == hist[n_edge]; m--) begin
                m_len++;
            end
            pend = (m_len == S);
            pval = hist[n_edge];
        end
    end

    initial forever begin
        @(negedge clk);
        check("model_lamp", bus.lamp_out, m_lamp);
        check("model_fault", {2'b00, bus.fault}, {2'b00, m_fault});
        check("model_code", {1'b0, bus.fault_code}, {1'b0, m_code});
    end

    logic [2:0] seq [3] = '{3'b010, 3'b100, 3'b001};

    task automatic hold(input logic [2:0] v, input int cyc);
        bus.light_in = v;
        repeat (cyc) @(negedge clk);
    endtask

    initial begin
        bus.light_in    = 3'b001;
        bus.clear_fault = 1'b0;
        @(negedge clk);
        check("rst_lamp", bus.lamp_out, 3'b001);
        check("rst_fault", {2'b00, bus.fault}, 3'b000);
        check("rst_code", {1'b0, bus.fault_code}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("init_run_lamp", bus.lamp_out, 3'b001);

        for (int i = 0; i < 3; i++) begin
            bus.light_in = seq[i];
            repeat (4) @(negedge clk);
            check("seq_before", bus.lamp_out, (i == 0) ? 3'b001 : seq[i-1]);
            @(negedge clk);
            check("seq_after", bus.lamp_out, seq[i]);
            repeat (5) @(negedge clk);
        end

        hold(3'b010, 10);
        hold(3'b011, 3);
        hold(3'b010, 10);
        check("glitch_lamp", bus.lamp_out, 3'b010);
        check("glitch_fault", {2'b00, bus.fault}, 3'b000);

        hold(3'b011, 5);
        check("illegal_fault", {2'b00, bus.fault}, 3'b001);
        check("illegal_code", {1'b0, bus.fault_code}, 3'b001);
        check("flash_first", bus.lamp_out, 3'b100);
        repeat (7) @(negedge clk);
        check("flash_hi_end", bus.lamp_out, 3'b100);
        @(negedge clk);
        check("flash_lo", bus.lamp_out, 3'b000);
        repeat (8) @(negedge clk);
        check("flash_hi2", bus.lamp_out, 3'b100);

        bus.light_in    = 3'b001;
        bus.clear_fault = 1'b1;
        @(negedge clk);
        bus.clear_fault = 1'b0;
        check("clear_lamp", bus.lamp_out, 3'b001);
        check("clear_fault", {2'b00, bus.fault}, 3'b000);
        check("clear_code", {1'b0, bus.fault_code}, 3'b000);
        repeat (10) @(negedge clk);

        hold(3'b100, 5);
        check("skip_code", {1'b0, bus.fault_code}, 3'b010);
        repeat (3) @(negedge clk);

        bus.light_in = 3'b010;
        repeat (4) @(negedge clk);
        bus.clear_fault = 1'b1;
        @(negedge clk);
        bus.clear_fault = 1'b0;
        check("clr_acc_lamp", bus.lamp_out, 3'b001);
        check("clr_acc_fault", {2'b00, bus.fault}, 3'b000);
        repeat (4) @(negedge clk);
        check("reacc_pre", bus.lamp_out, 3'b001);
        @(negedge clk);
        check("reacc_post", bus.lamp_out, 3'b010);

        repeat (70) @(negedge clk);
        check("wdog_code", {1'b0, bus.fault_code}, WD_ON ? 3'b011 : 3'b000);
        check("wdog_fault", {2'b00, bus.fault}, {2'b00, WD_ON});

        hold(3'b111, 5);
        check("pre_rst_fault", {2'b00, bus.fault}, 3'b001);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_lamp", bus.lamp_out, 3'b001);
        check("async_fault", {2'b00, bus.fault}, 3'b000);
        check("async_code", {1'b0, bus.fault_code}, 3'b000);
        bus.light_in = 3'b001;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        hold(3'b010, 10);
        check("post_rst_lamp", bus.lamp_out, 3'b010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lamp_sequence_monitor.md
# lamp_sequence_monitor

Downstream stage of the three-phase lamp sequencer: consumes its one-hot `light` code, deglitches it, checks the RED→GREEN→YELLOW→RED sequence and drives the physical lamp outputs. On an illegal code, an illegal transition or a stuck sequencer, it latches a fault and drives a fail-safe flashing-yellow pattern until software clears it.

## Interface
- `STABLE_CYCLES`, 4: consecutive identical samples needed to accept an input code (≥2).
- `FLASH_HALF`, 8: half-period of the fail-safe flash, in clock cycles (≥1).
- `WDOG_CYCLES`, 64: maximum cycles in RUN without an accepted new code (watchdog builds only).
- `clk`  input  1  clock, rising edge.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `light_in`  input  3  sequencer code; RED=001, GREEN=010, YELLOW=100.
- `clear_fault`  input  1  single-cycle pulse; leaves FAULT.
- `lamp_out`  output  3  registered lamp drive, same encoding as `light_in`.
- `fault`  output  1  registered; 1 while in FAULT.
- `fault_code`  output  2  registered; 00 none, 01 illegal code, 10 illegal sequence, 11 watchdog.

## Operation
- Sample register `s` captures `light_in` every cycle. Run counter `cnt` (width $clog2(STABLE_CYCLES+1)): it loads 1 when the new sample differs from `s`, otherwise increments, saturating at STABLE_CYCLES.
- Accept pulse: one cycle, when `cnt` steps from STABLE_CYCLES-1 to STABLE_CYCLES. Exactly one per stable run; accepted value = `s`.
- FSM states: INIT, RUN, FAULT.
- INIT: `lamp_out`=001. On accept:
  - one-hot value → RUN, `lamp_out`=value.
  - otherwise → FAULT, code 01.
- RUN: on accept:
  - value equal to `lamp_out`: no change; a glitch that returned is harmless.
  - value is the legal successor (001→010→100→001): `lamp_out` updates.
  - value not one-hot → FAULT, code 01.
  - value one-hot but not the successor → FAULT, code 10.
- FAULT:
  - `fault`=1.
  - `lamp_out` alternates 100 / 000, FLASH_HALF cycles each, starting at 100 in the first FAULT cycle.
  - Accepts are ignored.
  - `clear_fault`=1 → INIT: `lamp_out`=001, `fault`=0, `fault_code`=00, `cnt` reset to 0.
- `clear_fault` outside FAULT is ignored.
- `fault_code` holds its value until cleared.

## Timing
- Reset (asynchronous, immediate): state INIT, `lamp_out`=001, `fault`=0, `fault_code`=00, `s`=000, `cnt`=0, flash and watchdog counters 0.
- Latency: the first edge that samples a new `light_in` is edge k; `lamp_out` or `fault` changes at edge k+STABLE_CYCLES. With the default, the change is sampled at edge 1 and takes effect at edge 5.
- Pulses shorter than STABLE_CYCLES samples never produce an accept.
- FAULT entry is visible on `fault` at the same edge that `lamp_out` first shows 100.
- `clear_fault` and an accept in the same FAULT cycle: clear wins and the filter restarts.
- Accept and watchdog expiry in the same cycle: the accept is evaluated first. A legal accept reloads the watchdog; an illegal accept reports 01 or 10, not 11.
- Reset asserted mid-flash or mid-filter run: all state is abandoned immediately.

## Configuration
- `LAMP_SEQ_MON_WDOG_EN` defined:
  - Watchdog counter runs in RUN and is cleared on every accept that changes `lamp_out`.
  - When it reaches WDOG_CYCLES → FAULT, code 11.
  - The counter is held at 0 outside RUN.
- Undefined: no watchdog logic. RUN holds indefinitely on a constant input, and code 11 is never produced.

## Test plan
- Reset, hold `light_in`=001 → accept at edge 4; `lamp_out` stays 001 and the FSM enters RUN; `fault`=0.
- Drive the sequence 001→010→100→001, each held 10 cycles → `lamp_out` follows, each change 4 edges after it is sampled; `fault` stays 0.
- In RUN on 010, apply a 3-cycle 011 glitch, then back to 010 → no change and no fault. Hold 011 for 4 samples instead → `fault`=1, `fault_code`=01, `lamp_out` 100×8 then 000×8, repeating.
- In RUN on 001, hold 100 (skipping GREEN) → `fault_code`=10. Pulse `clear_fault` together with an accept → INIT, `lamp_out`=001, `fault`=0, and the next accept arrives 4 samples later.
- With `LAMP_SEQ_MON_WDOG_EN`, hold 010 for 64 cycles after its accept → `fault_code`=11. Without the macro, the same stimulus never faults.
- Assert `rst_n`=0 mid-flash → `lamp_out`=001, `fault`=0 and `fault_code`=00 immediately, without waiting for a clock edge.
